// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives instruction memory and
// fills the IF/ID pipeline register under stall, flush and redirect control.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [31:0]     fetch_count
);

    logic            en_q, en_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] ipc4_q, ipc4_d;
    logic [31:0]     count_q, count_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_tgt;

    assign pc_plus4     = pc_q + XLEN'(4);
    // Targets are forced word-aligned; misaligned low bits are dropped.
    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    always_comb begin
        en_d    = 1'b1;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        count_d = count_q;

        if (!en_q) begin
            // Startup cycle: memory not yet enabled, so only a bubble can enter.
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else begin
            if (redirect) begin
                pc_d = redirect_tgt;
            end else if (!stall) begin
                pc_d = pc_plus4;
            end

            if (flush || redirect) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end else if (!stall) begin
                valid_d = 1'b1;
                instr_d = imem_rdata;
                ipc_d   = pc_q;
                ipc4_d  = pc_plus4;
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            ipc4_q  <= '0;
            count_q <= '0;
        end else begin
            en_q    <= en_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            count_q <= count_d;
        end
    end

    assign imem_en       = en_q;
    assign imem_addr     = pc_q;
    assign ifid_valid    = valid_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc       = ipc_q;
    assign ifid_pc_plus4 = ipc4_q;
    assign fetch_count   = count_q;

endmodule
